// File: rtl/uart_if.sv
// Receive half of the 8051 UART in serial mode 1: oversampled start/8 data/stop
// deserialiser with majority voting, receive buffer and next-RI computation.
module uart_if #(
   parameter int OSR = 16
) (
   input  logic       clk_uart,
   input  logic       rst_n,
   input  logic       rxd_int_in,
   input  logic       rxd,
   output logic [7:0] r_data,
   output logic       rxd_int
);

   localparam int SW = $clog2(OSR);
   localparam logic [SW-1:0] SC_LO   = SW'(OSR / 2 - 1);
   localparam logic [SW-1:0] SC_MID  = SW'(OSR / 2);
   localparam logic [SW-1:0] SC_DEC  = SW'(OSR / 2 + 1);
   localparam logic [SW-1:0] SC_WRAP = SW'(OSR - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] sc_q, sc_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic [7:0]    shiftReg_q, shiftReg_d;
   logic [7:0]    rData_q, rData_d;
   logic [1:0]    samp_q, samp_d;
   logic          sync1_q, sync2_q, prevS_q;
   logic          rxdS, majority, atDecision, atWrap, frameLoad;

   assign rxdS       = sync2_q;
   assign atDecision = (sc_q == SC_DEC);
   assign atWrap     = (sc_q == SC_WRAP);
   assign majority   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxdS) | (samp_q[1] & rxdS);

   // The rest of the chip sees reset as active-high despite the port name.
   always_ff @(posedge clk_uart) begin
      if (rst_n) begin
         state_q    <= IDLE;
         sc_q       <= '0;
         bitIdx_q   <= '0;
         shiftReg_q <= '0;
         rData_q    <= '0;
         samp_q     <= '0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prevS_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         sc_q       <= sc_d;
         bitIdx_q   <= bitIdx_d;
         shiftReg_q <= shiftReg_d;
         rData_q    <= rData_d;
         samp_q     <= samp_d;
         sync1_q    <= rxd;
         sync2_q    <= sync1_q;
         prevS_q    <= rxdS;
      end
   end

   always_comb begin
      state_d    = state_q;
      sc_d       = atWrap ? '0 : sc_q + SW'(1);
      bitIdx_d   = bitIdx_q;
      shiftReg_d = shiftReg_q;
      rData_d    = rData_q;
      samp_d     = samp_q;
      frameLoad  = 1'b0;

      if (sc_q == SC_LO)  samp_d[0] = rxdS;
      if (sc_q == SC_MID) samp_d[1] = rxdS;

      case (state_q)
         // The edge cycle itself counts as sample 0, so the counter resumes at 1.
         IDLE: begin
            sc_d = '0;
            if (!rxdS && prevS_q) begin
               state_d = START;
               sc_d    = SW'(1);
            end
         end
         START: begin
            if (atDecision && majority) begin
               state_d = IDLE;
            end else if (atWrap) begin
               state_d  = DATA;
               bitIdx_d = '0;
            end
         end
         DATA: begin
            if (atDecision) shiftReg_d = {majority, shiftReg_q[7:1]};
            if (atWrap) begin
               if (bitIdx_q == 3'd7) state_d = STOP;
               else                  bitIdx_d = bitIdx_q + 3'd1;
            end
         end
         STOP: begin
            if (atDecision) begin
               state_d = IDLE;
               if (majority && !rxd_int_in) begin
                  frameLoad = 1'b1;
                  rData_d   = shiftReg_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign r_data  = rData_q;
   assign rxd_int = !rst_n && (rxd_int_in || frameLoad);

endmodule

// File: tb/tb_uart_if.sv
// Scoreboard bench for uart_if: frames are queued when driven and checked when
// the DUT raises a fresh RI load.
module tb_uart_if;

   localparam int OSR = 16;

   logic       clk_uart = 1'b0;
   logic       rst_n    = 1'b1;
   logic       rxd      = 1'b1;
   logic       rxdIntIn;
   logic [7:0] r_data;
   logic       rxd_int;

   logic       fbEnable = 1'b0;
   logic       forceVal = 1'b1;
   logic       riReg    = 1'b0;

   int         vectors     = 0;
   int         miscompares = 0;
   int         cycle       = 0;
   int         startCycle  = 0;
   int         loadCount   = 0;
   int         highRun     = 0;
   int         lastRun     = 0;
   bit         pendingCheck = 1'b0;
   logic [7:0] expQ[$];

   uart_if #(.OSR(OSR)) dut (
      .clk_uart  (clk_uart),
      .rst_n     (rst_n),
      .rxd_int_in(rxdIntIn),
      .rxd       (rxd),
      .r_data    (r_data),
      .rxd_int   (rxd_int)
   );

   always #5 clk_uart = ~clk_uart;

   assign rxdIntIn = fbEnable ? riReg : forceVal;

   // Stand-in for the SFR block that registers RI and feeds it back.
   always @(posedge clk_uart) begin
      riReg <= rxd_int;
      cycle <= cycle + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // A load is RI going high while the fed-back flag is still clear.
   always @(negedge clk_uart) begin
      int lat;
      if (pendingCheck) begin
         pendingCheck = 1'b0;
         checkOutput("sbHasEntry", (expQ.size() > 0), 1);
         if (expQ.size() > 0) checkOutput("rData", r_data, expQ.pop_front());
      end
      if (rxd_int && !rxdIntIn && !rst_n) begin
         loadCount++;
         pendingCheck = 1'b1;
         lat = cycle - startCycle;
         checkOutput("latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
      end
      if (rxd_int) highRun++;
      else if (highRun > 0) begin
         lastRun = highRun;
         highRun = 0;
      end
   end

   task automatic driveBit(input logic b);
      rxd = b;
      repeat (OSR) @(negedge clk_uart);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit expectLoad);
      if (expectLoad) expQ.push_back(data);
      startCycle = cycle;
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(data[i]);
      driveBit(stopBit);
      driveBit(1'b1);
      driveBit(1'b1);
   endtask

   initial begin
      int loadsBefore;

      // Reset with RI forced high: the output must still be held low.
      repeat (4) @(negedge clk_uart);
      checkOutput("rstRData", r_data, 8'h00);
      checkOutput("rstFlag", rxd_int, 0);
      rst_n    = 1'b0;
      forceVal = 1'b0;
      driveBit(1'b1);
      driveBit(1'b1);

      // Flag fed back: it must stay set after the load.
      fbEnable = 1'b1;
      applyStimulus(8'h3B, 1'b1, 1'b1);
      checkOutput("flagHeld1", rxd_int, 1);
      driveBit(1'b1);
      checkOutput("flagHeld2", rxd_int, 1);

      // Software clears RI after every frame: single-cycle pulses.
      fbEnable = 1'b0;
      forceVal = 1'b0;
      driveBit(1'b1);
      for (int f = 0; f < 2; f++) begin
         applyStimulus(8'h3B, 1'b1, 1'b1);
         checkOutput("pulseWidth", lastRun, 1);
      end

      // Overrun: previous byte unacknowledged, new frame discarded.
      forceVal = 1'b1;
      applyStimulus(8'hA5, 1'b1, 1'b0);
      checkOutput("overrunRData", r_data, 8'h3B);
      checkOutput("overrunFlag", rxd_int, 1);
      forceVal = 1'b0;
      driveBit(1'b1);

      // Short glitch is a false start.
      loadsBefore = loadCount;
      rxd = 1'b0;
      repeat (4) @(negedge clk_uart);
      driveBit(1'b1);
      driveBit(1'b1);
      driveBit(1'b1);
      checkOutput("glitchLoads", loadCount, loadsBefore);
      checkOutput("glitchRData", r_data, 8'h3B);
      checkOutput("glitchFlag", rxd_int, 0);

      // Framing error, then a good frame.
      loadsBefore = loadCount;
      applyStimulus(8'h55, 1'b0, 1'b0);
      checkOutput("frameErrLoads", loadCount, loadsBefore);
      checkOutput("frameErrRData", r_data, 8'h3B);
      applyStimulus(8'h0F, 1'b1, 1'b1);

      // Reset in the middle of the data bits.
      rxd = 1'b0;
      repeat (OSR) @(negedge clk_uart);
      driveBit(1'b1);
      driveBit(1'b1);
      driveBit(1'b0);
      rst_n    = 1'b1;
      forceVal = 1'b1;
      rxd      = 1'b1;
      repeat (3) @(negedge clk_uart);
      checkOutput("midRstFlag", rxd_int, 0);
      rst_n    = 1'b0;
      forceVal = 1'b0;
      driveBit(1'b1);
      driveBit(1'b1);
      checkOutput("postRstRData", r_data, 8'h00);
      checkOutput("postRstFlag", rxd_int, 0);
      applyStimulus(8'hC3, 1'b1, 1'b1);

      repeat (4) @(negedge clk_uart);
      checkOutput("sbDrained", expQ.size(), 0);
      checkOutput("totalLoads", loadCount, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_if.md
Name: uart_if

Overview:
- Receive-side serial interface for the 8051 core's UART, in 8-bit asynchronous mode (serial mode 1).
- Oversamples the serial input `rxd` using `clk_uart`, a 16x baud clock.
- Deserialises 1 start bit, 8 data bits (LSB first) and 1 stop bit into the receive buffer `r_data`.
- Computes the next value of the receive-interrupt flag (RI); the SFR block registers that flag and feeds it back.

Parameters:
- OSR, 16, clk_uart cycles per bit. Must be even and at least 4.

Ports:
- clk_uart  input  1  UART oversampling clock. All state changes on its rising edge.
- rst_n  input  1  Reset. Synchronous, active-high: asserted when 1, despite the name.
- rxd_int_in  input  1  Current registered RI flag, fed back from the SFR block.
- rxd  input  1  Serial receive line. Asynchronous; idles high.
- r_data  output  8  Receive buffer (SBUF). Registered.
- rxd_int  output  1  Next RI value. Combinational.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - r_data=8'h00.
  - FSM goes to IDLE and bit/sample counters clear.
  - Synchroniser flops are set to 1.
  - While rst_n=1, rxd_int=0.
- Input sync: rxd passes through 2 flip-flops to give rxd_s. All decisions use rxd_s.
- Sample counter `sc` runs 0..OSR-1 within each bit. Bit decision is the majority of rxd_s at sc = OSR/2-1, OSR/2 and OSR/2+1, taken at sc=OSR/2+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on the first cycle rxd_s=0 (falling edge, previous rxd_s=1), go to START with sc=0. A line held low does not retrigger.
  - START: at the decision point:
    - majority=1 is a false start: return to IDLE, no flag, r_data unchanged.
    - majority=0: continue to DATA at the next sc wrap.
  - DATA: 8 bits, LSB first, shifted into an internal shift register. Bit index 0..7 advances on each sc wrap. After bit 7 go to STOP.
  - STOP: at the decision point, the frame completes and the FSM returns to IDLE in the same cycle.
- Frame completion:
  - If stop majority=1 and rxd_int_in=0: r_data <= shift register (visible next cycle), and rxd_int=1 for that cycle.
  - If stop=0 (framing error): frame discarded, r_data unchanged, no flag.
  - If rxd_int_in=1 (previous byte not yet acknowledged): frame discarded, r_data unchanged (overrun: old byte kept).
- rxd_int = rxd_int_in OR frame_load. RI is never cleared here; it is cleared only by the external register (software).
- Timing, with the cycle rxd_s first reads 0 in IDLE as cycle 0:
  - The decision for bit k (0=start, 9=stop) falls at cycle OSR*k + OSR/2+1.
  - With OSR=16 the stop decision, and any load/flag, is at cycle 153, i.e. 155 cycles after the pin edge.
- Back-to-back frames: after the STOP decision a new start edge is accepted. The minimum gap is the rest of the stop bit, since a falling edge needs rxd_s=1 first.
- Reset mid-frame aborts the frame with no load and no flag. Glitches shorter than 2 of the 3 mid-bit samples are rejected.

Test Plan:
1. Line stimulus, 1 bit = 16 clk_uart cycles, looped: idle 1 for 2 bits, start 0, data bits 1,1,0,1,1,1,0,0, stop 1. Feedback rxd_int_in = registered rxd_int while enabled. Required: r_data=8'h3B after the frame; rxd_int rises 155±1 cycles after the start edge; the flag stays 1 while fed back.
2. Same frame with rxd_int_in forced to 0 after each frame: rxd_int pulses 1 for exactly one cycle per frame, and r_data=8'h3B every frame.
3. rxd_int_in held 1, then a frame carrying 8'hA5 after r_data=8'h3B: r_data stays 8'h3B and rxd_int stays 1 (overrun discard).
4. Low pulse of 4 cycles on an idle line: FSM returns to IDLE; no flag; r_data unchanged.
5. Frame 8'h55 with stop bit driven 0: no flag; r_data unchanged; the next valid frame 8'h0F loads normally.
6. rst_n=1 asserted mid-DATA, then released with the line idle high: r_data=8'h00; rxd_int=0; the next full frame 8'hC3 is received correctly.
